// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: ORA state encoding and the default signature
// configuration used by both the pattern generator and the response analyser.
// Latency: n/a (types and constants only). Backpressure: n/a.
package lbist_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int         LBIST_BITS   = 4;
   localparam logic [3:0] LBIST_POLY   = 4'b0011;
   localparam logic [3:0] LBIST_SEED   = 4'b0000;
   localparam logic [3:0] LBIST_GOLDEN = 4'b0010;

endpackage

// File: rtl/lbist_ora_if.sv
// Control/response bundle between the BIST controller + CUT and the ORA.
// Latency: n/a (wires only). Backpressure: none, responses are taken when valid.
// Optional: LBIST_ORA_XMASK_EN adds resp_mask (X-source bit mask).
interface lbist_ora_if #(
   parameter int BITS = 4
);
   logic            start;
   logic            abort;
   logic            resp_valid;
   logic [BITS-1:0] resp;
`ifdef LBIST_ORA_XMASK_EN
   logic [BITS-1:0] resp_mask;
`endif
   logic            busy;
   logic            done;
   logic            pass;
   logic [BITS-1:0] signature;

   // master: controller/CUT side that drives the analyser
   modport master (
`ifdef LBIST_ORA_XMASK_EN
      output resp_mask,
`endif
      output start, abort, resp_valid, resp,
      input  busy, done, pass, signature
   );

   // slave: the analyser itself
   modport slave (
`ifdef LBIST_ORA_XMASK_EN
      input  resp_mask,
`endif
      input  start, abort, resp_valid, resp,
      output busy, done, pass, signature
   );
endinterface

// File: rtl/lbist_ora_misr.sv
// Multiple-input signature register: shifts toward bit 0, feedback into the MSB.
// Latency: a word taken with en is in sig after the same edge. Backpressure: none.
// Ports: clk, rst (async active-low, resets to seed), load, seed, en, din, sig.
module misr #(
   parameter int              BITS = 4,
   parameter logic [BITS-1:0] POLY = 4'b0011
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [BITS-1:0] seed,
   input  logic            en,
   input  logic [BITS-1:0] din,
   output logic [BITS-1:0] sig
);

   logic fb;

   assign fb = ^(POLY & sig);

   // seed is tied to a constant by the parent, so the reset value is static
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sig <= seed;
      end else if (load) begin
         sig <= seed;
      end else if (en) begin
         sig <= {fb ^ din[BITS-1], sig[BITS-1:1] ^ din[BITS-2:0]};
      end
   end

endmodule

// File: rtl/lbist_ora.sv
// LBIST output response analyser: compacts PATTERNS valid responses, then compares with GOLDEN.
// Latency: signature updates the edge a response is taken; done/pass two edges after the last one.
// Backpressure: none; resp_valid is ignored outside RUN, start is ignored in RUN/CHECK.
// Ports: clk, rst (async active-low), bus (lbist_ora_if.slave). Option: LBIST_ORA_XMASK_EN.
module lbist_ora
   import lbist_pkg::*;
#(
   parameter int              BITS     = LBIST_BITS,
   parameter logic [BITS-1:0] POLY     = BITS'(LBIST_POLY),
   parameter logic [BITS-1:0] SEED     = BITS'(LBIST_SEED),
   parameter logic [BITS-1:0] GOLDEN   = BITS'(LBIST_GOLDEN),
   parameter int              PATTERNS = 4
) (
   input  logic        clk,
   input  logic        rst,
   lbist_ora_if.slave  bus
);

   localparam int CW = $clog2(PATTERNS + 1);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            busy_q;
   logic            done_q;
   logic            pass_q;
   logic [BITS-1:0] din;
   logic [BITS-1:0] sig;
   logic            load;
   logic            en;
   logic            last;

`ifdef LBIST_ORA_XMASK_EN
   // unknown bits are forced to 0 so they cannot corrupt the signature
   assign din = bus.resp & ~bus.resp_mask;
`else
   assign din = bus.resp;
`endif

   // abort wins over everything; start only counts from IDLE/DONE
   assign load = !bus.abort && bus.start && (state == IDLE || state == DONE);
   assign en   = !bus.abort && bus.resp_valid && (state == RUN);
   assign last = en && (cnt == CW'(PATTERNS - 1));

   misr #(
      .BITS (BITS),
      .POLY (POLY)
   ) u_misr (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .seed (SEED),
      .en   (en),
      .din  (din),
      .sig  (sig)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
      end else if (bus.abort) begin
         state  <= IDLE;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state  <= RUN;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  done_q <= 1'b0;
                  pass_q <= 1'b0;
               end
            end
            RUN: begin
               if (en) begin
                  cnt <= cnt + CW'(1);
               end
               if (last) begin
                  state <= CHECK;
               end
            end
            CHECK: begin
               // the MISR already holds the final step taken on the previous edge
               pass_q <= (sig == GOLDEN);
               state  <= DONE;
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.signature = sig;

endmodule

// File: tb/tb_lbist_ora.sv
// Directed bench for lbist_ora: two instances share stimulus, one with the default
// GOLDEN and one with GOLDEN=4'b1111, so pass and fail verdicts are seen on the same runs.
module tb_lbist_ora;

   logic       clk;
   logic       rst;
   logic       start;
   logic       abort;
   logic       resp_valid;
   logic [3:0] resp;
`ifdef LBIST_ORA_XMASK_EN
   logic [3:0] resp_mask;
`endif

   int n_chk;
   int n_fail;

   // expected signature after responses 1..4 of {0001,0000,0000,0000}, and the verdict
   logic [3:0] exp_sig [4];
   logic       exp_pass;

   lbist_ora_if #(.BITS(4)) ifa ();
   lbist_ora_if #(.BITS(4)) ifb ();

   assign ifa.start      = start;
   assign ifa.abort      = abort;
   assign ifa.resp_valid = resp_valid;
   assign ifa.resp       = resp;
   assign ifb.start      = start;
   assign ifb.abort      = abort;
   assign ifb.resp_valid = resp_valid;
   assign ifb.resp       = resp;
`ifdef LBIST_ORA_XMASK_EN
   assign ifa.resp_mask  = resp_mask;
   assign ifb.resp_mask  = resp_mask;
`endif

   lbist_ora dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   lbist_ora #(.GOLDEN(4'b1111)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // advance one rising edge and settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic give(input logic [3:0] r);
      resp_valid = 1'b1;
      resp       = r;
      step();
      resp_valid = 1'b0;
      resp       = 4'hF;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
`ifdef LBIST_ORA_XMASK_EN
      resp_mask  = 4'b0001;
      exp_sig[0] = 4'b0000;
      exp_sig[1] = 4'b0000;
      exp_sig[2] = 4'b0000;
      exp_sig[3] = 4'b0000;
      exp_pass   = 1'b0;
`else
      exp_sig[0] = 4'b0001;
      exp_sig[1] = 4'b1000;
      exp_sig[2] = 4'b0100;
      exp_sig[3] = 4'b0010;
      exp_pass   = 1'b1;
`endif
      rst        = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      resp_valid = 1'b0;
      resp       = 4'h0;

      // reset state
      step();
      chk("rst_busy", ifa.busy, 1'b0);
      chk("rst_done", ifa.done, 1'b0);
      chk("rst_pass", ifa.pass, 1'b0);
      chk("rst_sig",  ifa.signature, 4'h0);
      rst = 1'b1;
      step();
      chk("idle_busy", ifa.busy, 1'b0);

      // basic run
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_busy", ifa.busy, 1'b1);
      chk("start_sig",  ifa.signature, 4'h0);
      give(4'b0001);
      chk("r1_sig", ifa.signature, exp_sig[0]);
      give(4'b0000);
      chk("r2_sig", ifa.signature, exp_sig[1]);
      give(4'b0000);
      chk("r3_sig", ifa.signature, exp_sig[2]);
      give(4'b0000);
      chk("r4_sig",   ifa.signature, exp_sig[3]);
      chk("chk_busy", ifa.busy, 1'b1);
      chk("chk_done", ifa.done, 1'b0);
      step();
      chk("done_a",   ifa.done, 1'b1);
      chk("busy_a",   ifa.busy, 1'b0);
      chk("pass_a",   ifa.pass, exp_pass);
      chk("done_b",   ifb.done, 1'b1);
      chk("pass_b",   ifb.pass, 1'b0);

      // DONE ignores responses and holds its result
      give(4'b1111);
      chk("hold_sig",  ifa.signature, exp_sig[3]);
      chk("hold_done", ifa.done, 1'b1);
      chk("hold_pass", ifa.pass, exp_pass);

      // restart from DONE, with 3-cycle validity gaps
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_done", ifa.done, 1'b0);
      chk("restart_busy", ifa.busy, 1'b1);
      chk("restart_sig",  ifa.signature, 4'h0);
      give(4'b0001);
      step(); step(); step();
      chk("gap1_sig", ifa.signature, exp_sig[0]);
      give(4'b0000);
      step(); step(); step();
      chk("gap2_sig", ifa.signature, exp_sig[1]);
      give(4'b0000);
      step(); step(); step();
      chk("gap3_sig", ifa.signature, exp_sig[2]);
      give(4'b0000);
      chk("gap4_sig", ifa.signature, exp_sig[3]);
      step();
      chk("gap_done", ifa.done, 1'b1);
      chk("gap_pass", ifa.pass, exp_pass);

      // abort after two responses; start in RUN is ignored
      start = 1'b1;
      step();
      start = 1'b0;
      give(4'b0001);
      start = 1'b1;
      give(4'b0000);
      start = 1'b0;
      chk("run_start_ign", ifa.signature, exp_sig[1]);
      abort = 1'b1;
      start = 1'b1;
      step();
      abort = 1'b0;
      start = 1'b0;
      chk("abort_busy", ifa.busy, 1'b0);
      chk("abort_done", ifa.done, 1'b0);
      chk("abort_sig",  ifa.signature, exp_sig[1]);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("reload_sig", ifa.signature, 4'h0);
      give(4'b0001);
      give(4'b0000);
      give(4'b0000);
      give(4'b0000);
      step();
      chk("post_abort_done", ifa.done, 1'b1);
      chk("post_abort_pass", ifa.pass, exp_pass);
      chk("post_abort_sig",  ifa.signature, exp_sig[3]);

      // reset pulsed mid-run takes effect without a clock edge
      start = 1'b1;
      step();
      start = 1'b0;
      give(4'b0001);
      give(4'b0000);
      #2;
      rst   = 1'b0;
      start = 1'b1;
      #1;
      chk("arst_busy", ifa.busy, 1'b0);
      chk("arst_done", ifa.done, 1'b0);
      chk("arst_pass", ifa.pass, 1'b0);
      chk("arst_sig",  ifa.signature, 4'h0);
      step();
      chk("rst_start_ign", ifa.busy, 1'b0);
      start = 1'b0;
      rst   = 1'b1;
      step();
      chk("rst_rel_busy", ifa.busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/lbist_ora.md
# lbist_ora

Output response analyser for the LBIST loop. It compacts the circuit-under-test responses produced for each `rpg` pattern into a multiple-input signature register (MISR). After a programmed number of patterns, it compares the final signature against a golden value and reports pass/fail. It sits on the CUT output side, mirroring the pattern generator on the CUT input side, and is started by the BIST controller.

## Interface
- `BITS`, 4, response and signature width; must be at least 2
- `POLY`, 4'b0011, feedback tap mask; bit i set means `sig[i]` feeds the XOR feedback
- `SEED`, 0, signature value loaded on `start`
- `GOLDEN`, 4'b0010, expected final signature
- `PATTERNS`, 4, number of valid responses compacted per run; must be at least 1
- `clk` input 1: single clock; all state changes on its rising edge
- `rst` input 1: asynchronous, active-low reset
- `start` input 1: begin a run; accepted only in IDLE or DONE
- `abort` input 1: return to IDLE from any state
- `resp_valid` input 1: `resp` holds a valid CUT response this cycle
- `resp` input BITS: CUT response word
- `busy` output 1: high in RUN and CHECK
- `done` output 1: high in DONE
- `pass` output 1: registered compare result; meaningful only while `done` is high
- `signature` output BITS: current MISR contents

## Operation
- State machine states: IDLE, RUN, CHECK, DONE.
- Reset (`rst`=0), asynchronous:
  - state becomes IDLE
  - `signature` = SEED
  - pattern count = 0
  - `pass` = 0, `busy` = 0, `done` = 0
- IDLE or DONE with `start`=1:
  - `signature` is loaded with SEED and the count is cleared
  - state goes to RUN
  - `pass` is cleared
- RUN with `resp_valid`=1, the MISR step is:
  - fb = XOR-reduce(POLY & sig)
  - sig'[BITS-1] = fb ^ resp[BITS-1]
  - sig'[i] = sig[i+1] ^ resp[i] for i < BITS-1
  - count increments
- RUN with `resp_valid`=0: `signature` and count hold.
- RUN, when the accepted response is number PATTERNS (count == PATTERNS-1 with `resp_valid`=1): the final step is applied and state goes to CHECK.
- CHECK: `pass` <= (`signature` == GOLDEN); state goes to DONE. Any `resp_valid` in this state is ignored.
- DONE:
  - holds `signature`, `pass` and `done` until `start` or `abort`
  - `resp_valid` is ignored
- `start` in RUN or CHECK is ignored.
- `abort` has priority over `start` and `resp_valid`. It sends the FSM to IDLE and clears count and `pass`. `signature` holds its last value.
- Counter width is $clog2(PATTERNS+1); it never wraps within a run.
- All arithmetic is BITS-wide XOR only; no carries.

## Timing
- `start` sampled at edge k: `busy`=1 and `signature`=SEED after edge k.
- A response sampled at edge k is reflected in `signature` after edge k.
- Last response sampled at edge k:
  - CHECK after edge k
  - `done`=1 and `pass` valid after edge k+1
- Latency from the last response to `done` is two edges.
- `start` sampled in DONE at edge k: `done`=0 and `busy`=1 after edge k.
- Reset asserted mid-run: all outputs take their reset values immediately, without waiting for a clock edge.
- Reset release is synchronous to the next rising edge.

## Configuration
- `LBIST_ORA_XMASK_EN` defined:
  - adds input `resp_mask` [BITS-1:0]
  - the MISR uses `resp & ~resp_mask`, so unknown (X-source) bits are masked to 0 before compaction
- `LBIST_ORA_XMASK_EN` undefined: no `resp_mask` port; `resp` is used unmodified.

## Structure
- Shared package `lbist_pkg` holds:
  - the state typedef (IDLE/RUN/CHECK/DONE)
  - the default BITS, POLY, SEED and GOLDEN constants, shared with the pattern-generator configuration
- Sub-module `misr`:
  - parameters BITS and POLY
  - ports: `clk`, `rst`, `load`, `seed`, `en`, `din`, `sig`
  - holds only the compaction register
  - the FSM and counter live in `lbist_ora`

## Test plan
- Default parameters, `start`, then 4 responses 4'b0001, 0, 0, 0:
  - `signature` steps 0001, 1000, 0100, 0010
  - `done`=1 two edges after the last response, with `pass`=1
- Same stimulus with GOLDEN=4'b1111: `done`=1 and `pass`=0.
- Gaps in validity: `resp_valid` low for 3 cycles between responses. `signature` holds during the gaps; the final result is 0010 and `pass`=1.
- `abort` during RUN after 2 responses:
  - IDLE on the next edge; `busy`=0, `done`=0
  - a new `start` reloads SEED and a full run passes
- `rst` pulsed low mid-run: outputs go to reset values without a clock edge; `start` ignored while `rst`=0.
- `LBIST_ORA_XMASK_EN` with `resp_mask`=4'b0001, responses 4'b0001, 0, 0, 0: final `signature` 0000, `pass`=0 with GOLDEN=4'b0010.
